// File: rtl/cx_types_pkg.sv
// Shared fixed-point format constants and sample/phase types.
// Blocks pass these as parameter overrides to format converters.
package cx_types_pkg;

  localparam int WIDTH            = 16;
  localparam int FRAC_WIDTH       = 15;
  localparam int PHASE_WIDTH      = 32;
  localparam int PHASE_FRAC_WIDTH = 31;

  typedef logic signed [WIDTH-1:0]             sample_t;
  typedef logic signed [PHASE_WIDTH-1:0]       phase_t;
  typedef logic signed [WIDTH+PHASE_WIDTH-1:0] phase_mac_t;

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/fp_round_sat.sv
// Combinational fixed-point converter: align, round, range check, clamp/wrap.
// Ports: din (IN_W.IN_F signed) -> dout (OUT_W.OUT_F signed), ovf.
module fp_round_sat
  import cx_types_pkg::*;
#(
  parameter int IN_W     = WIDTH,
  parameter int IN_F     = FRAC_WIDTH,
  parameter int OUT_W    = WIDTH,
  parameter int OUT_F    = FRAC_WIDTH,
  parameter int ROUND    = 1,
  parameter int SATURATE = 1
) (
  input  logic signed [IN_W-1:0]  din,
  output logic signed [OUT_W-1:0] dout,
  output logic                    ovf
);

  localparam int SH = OUT_F - IN_F;
  localparam int LS = imax(SH, 0);
  localparam int RS = imax(-SH, 0);
  // One guard bit above the input so the rounding carry survives.
  localparam int MW = IN_W + LS + 1;

  localparam logic signed [OUT_W-1:0] MAXV = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic signed [OUT_W-1:0] MINV = {1'b1, {(OUT_W-1){1'b0}}};

  logic signed [MW-1:0] ext;
  logic signed [MW-1:0] val;

  assign ext = MW'(din);

  if (SH >= 0) begin : g_left
    assign val = ext <<< LS;
  end else begin : g_right
    localparam logic signed [MW-1:0] HALF =
      (ROUND != 0) ? (MW'(1) <<< (RS - 1)) : '0;
    assign val = (ext + HALF) >>> RS;
  end

  if (MW > OUT_W) begin : g_narrow
    // In range iff every bit from the output sign bit up matches.
    logic [MW-OUT_W:0] top;
    logic              in_rng;

    assign top    = val[MW-1:OUT_W-1];
    assign in_rng = (&top) | ~(|top);

    always_comb begin
      ovf  = ~in_rng;
      dout = val[OUT_W-1:0];
      if (!in_rng && SATURATE != 0) begin
        dout = val[MW-1] ? MINV : MAXV;
      end
    end
  end else begin : g_wide
    assign dout = OUT_W'(val);
    assign ovf  = 1'b0;
  end

endmodule

// File: rtl/fp_data.sv
// Two-stage registered fixed-point format converter (latency 2).
// Ports: clk, rst, din_valid/din in; dout_valid/dout/ovf out.
module fp_data
  import cx_types_pkg::*;
#(
  parameter int IN_W     = WIDTH,
  parameter int IN_F     = FRAC_WIDTH,
  parameter int OUT_W    = WIDTH,
  parameter int OUT_F    = FRAC_WIDTH,
  parameter int ROUND    = 1,
  parameter int SATURATE = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    din_valid,
  input  logic signed [IN_W-1:0]  din,
  output logic                    dout_valid,
  output logic signed [OUT_W-1:0] dout,
  output logic                    ovf
);

  if (IN_W < 2 || IN_W > 48 || IN_F < 0 || IN_F > IN_W ||
      OUT_W < 2 || OUT_W > 48 || OUT_F < 0 || OUT_F > OUT_W ||
      ROUND < 0 || ROUND > 1 || SATURATE < 0 || SATURATE > 1)
  begin : g_bad_param
    $error("fp_data: parameter out of range");
  end

  $info("fp_data: %0d.%0d -> %0d.%0d %s %s",
        IN_W, IN_F, OUT_W, OUT_F,
        (ROUND != 0) ? "round" : "trunc",
        (SATURATE != 0) ? "sat" : "wrap");

  logic                    s1_valid;
  logic signed [IN_W-1:0]  s1_data;
  logic signed [OUT_W-1:0] cv;
  logic                    cv_ovf;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
    end else begin
      s1_valid <= din_valid;
      if (din_valid) s1_data <= din;
    end
  end

  fp_round_sat #(
    .IN_W     (IN_W),
    .IN_F     (IN_F),
    .OUT_W    (OUT_W),
    .OUT_F    (OUT_F),
    .ROUND    (ROUND),
    .SATURATE (SATURATE)
  ) u_cvt (
    .din  (s1_data),
    .dout (cv),
    .ovf  (cv_ovf)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout_valid <= 1'b0;
      dout       <= '0;
      ovf        <= 1'b0;
    end else begin
      dout_valid <= s1_valid;
      if (s1_valid) begin
        dout <= cv;
        ovf  <= cv_ovf;
      end
    end
  end

endmodule

// File: tb/tb_fp_data.sv
// Bench for fp_data: several format configs driven in parallel,
// checked against an integer-arithmetic reference model.
module tb_fp_data;

  localparam int N = 10;
  localparam int CIW[N] = '{16, 8, 8, 8, 8, 8, 8, 16, 12, 16};
  localparam int CIF[N] = '{15, 4, 4, 2, 0, 0, 1, 12,  3, 10};
  localparam int COW[N] = '{16, 8, 8, 12, 4, 4, 7, 10, 16,  6};
  localparam int COF[N] = '{15, 2, 2, 6, 0, 0, 0,  4,  9,  0};
  localparam int CR[N]  = '{ 1, 1, 0, 1, 1, 1, 1,  1,  0,  0};
  localparam int CS[N]  = '{ 1, 1, 1, 1, 1, 0, 1,  0,  1,  0};

  logic          clk = 1'b0;
  logic          rst;
  logic          din_valid;
  logic [15:0]   din;
  logic [N-1:0]  dv;
  logic [N-1:0]  ov;
  logic [15:0]   dq[N];

  int ncmp = 0;
  int nbad = 0;

  bit          pv;
  logic [15:0] pd;
  logic [15:0] held;

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    logic [COW[g]-1:0] dd;
    fp_data #(
      .IN_W     (CIW[g]),
      .IN_F     (CIF[g]),
      .OUT_W    (COW[g]),
      .OUT_F    (COF[g]),
      .ROUND    (CR[g]),
      .SATURATE (CS[g])
    ) u_dut (
      .clk        (clk),
      .rst        (rst),
      .din_valid  (din_valid),
      .din        (din[CIW[g]-1:0]),
      .dout_valid (dv[g]),
      .dout       (dd),
      .ovf        (ov[g])
    );
    assign dq[g] = 16'(dd);
  end

  task automatic chk(input string tag, input logic [47:0] got,
                     input logic [47:0] exp);
    ncmp++;
    if (got !== exp) begin
      nbad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  function automatic longint fdiv(input longint a, input longint b);
    longint q;
    q = a / b;
    if ((a % b) != 0 && a < 0) q = q - 1;
    return q;
  endfunction

  task automatic conv(input int g, input logic [15:0] d,
                      output logic [15:0] r, output bit o);
    longint v, m, sc, hi, lo;
    int     sh;
    m = longint'(1) <<< CIW[g];
    v = longint'(d) & (m - 1);
    if (v >= m / 2) v = v - m;
    sh = COF[g] - CIF[g];
    if (sh >= 0) begin
      v = v * (longint'(1) <<< sh);
    end else begin
      sc = longint'(1) <<< (-sh);
      if (CR[g] != 0) v = v + sc / 2;
      v = fdiv(v, sc);
    end
    hi = (longint'(1) <<< (COW[g] - 1)) - 1;
    lo = -hi - 1;
    o  = (v > hi) || (v < lo);
    if (o && CS[g] != 0) v = (v > hi) ? hi : lo;
    r = 16'(v & ((longint'(1) <<< COW[g]) - 1));
  endtask

  task automatic check_all(input string ph, input bit ev);
    logic [15:0] r;
    bit          o;
    for (int g = 0; g < N; g++) begin
      conv(g, held, r, o);
      chk($sformatf("%s/valid%0d", ph, g), dv[g], ev);
      chk($sformatf("%s/dout%0d", ph, g), dq[g], r);
      chk($sformatf("%s/ovf%0d", ph, g), ov[g], o);
    end
  endtask

  task automatic check_zero(input string ph);
    for (int g = 0; g < N; g++) begin
      chk($sformatf("%s/valid%0d", ph, g), dv[g], 0);
      chk($sformatf("%s/dout%0d", ph, g), dq[g], 0);
      chk($sformatf("%s/ovf%0d", ph, g), ov[g], 0);
    end
  endtask

  // Outputs after this edge reflect the sample driven one step earlier.
  task automatic step(input string ph, input bit v, input logic [15:0] d);
    din_valid = v;
    din       = d;
    @(posedge clk);
    #1;
    if (pv) held = pd;
    check_all(ph, pv);
    pv = v;
    pd = d;
  endtask

  task automatic rand_steps(input int n);
    logic [15:0] d;
    bit          v;
    for (int i = 0; i < n; i++) begin
      v = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 7))
        0:       d = 16'h8000;
        1:       d = 16'h7FFF;
        2:       d = {8'h00, 8'($urandom_range(120, 135))};
        default: d = 16'($urandom);
      endcase
      step("rand", v, d);
    end
  endtask

  initial begin
    rst       = 1'b1;
    din_valid = 1'b0;
    din       = '0;
    pv        = 1'b0;
    pd        = '0;
    held      = '0;
    #1;
    check_zero("reset");
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    step("dir", 1'b1, 16'h8000);
    step("dir", 1'b1, 16'h7FFF);
    chk("id_min", dq[0], 16'h8000);
    chk("id_min_ovf", ov[0], 0);
    step("dir", 1'b1, 16'h0013);
    chk("id_max", dq[0], 16'h7FFF);
    step("dir", 1'b1, 16'h00ED);
    chk("rnd_pos", dq[1], 8'h05);
    chk("trunc_pos", dq[2], 8'h04);
    step("dir", 1'b1, 16'h0081);
    chk("rnd_neg", dq[1], 8'hFB);
    step("dir", 1'b1, 16'h007F);
    chk("lalign", dq[3], 12'h810);
    chk("lalign_ovf", ov[3], 0);
    step("dir", 1'b1, 16'h0080);
    chk("sat_hi", dq[4], 4'h7);
    chk("sat_hi_ovf", ov[4], 1);
    chk("wrap_hi", dq[5], 4'hF);
    chk("wrap_hi_ovf", ov[5], 1);
    chk("rnd_carry", dq[6], 7'h3F);
    chk("rnd_carry_ovf", ov[6], 1);
    step("dir", 1'b0, 16'h0000);
    chk("sat_lo", dq[4], 4'h8);
    chk("sat_lo_ovf", ov[4], 1);

    step("gap", 1'b1, 16'h1111);
    step("gap", 1'b0, 16'h2222);
    step("gap", 1'b1, 16'h3333);
    step("gap", 1'b0, 16'h4444);
    step("gap", 1'b0, 16'h5555);
    step("gap", 1'b1, 16'h6666);

    rand_steps(300);

    #3;
    rst = 1'b1;
    #1;
    check_zero("async_rst");
    din_valid = 1'b1;
    din       = 16'hABCD;
    repeat (2) @(posedge clk);
    #2;
    check_zero("in_rst");
    rst  = 1'b0;
    pv   = 1'b0;
    pd   = '0;
    held = '0;
    step("post_rst", 1'b0, 16'h1234);
    step("post_rst", 1'b1, 16'h4321);
    step("post_rst", 1'b0, 16'h0000);

    rand_steps(300);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
    $finish;
  end

endmodule
